// File: rtl/params.sv
// Shared width parameters for the value datapath.
// P is the MSB index of the consumer value port ([P:0]).
package params;
  localparam int P = 7;
endpackage

// File: rtl/val_source_pkg.sv
// val_source_pkg: state encoding and defaults for the val_source generator.
package val_source_pkg;
  import params::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } val_src_state_t;

  localparam int DEF_STEP = 1;
  localparam int DEF_W    = P + 1;
endpackage

// File: rtl/val_source_if.sv
// val_source_if: valid/ready beat channel from val_source to its consumer.
// Optional out_par when VAL_SOURCE_PARITY_EN is defined.
interface val_source_if #(
  parameter int W = val_source_pkg::DEF_W
) ();
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef VAL_SOURCE_PARITY_EN
  logic         out_par;

  modport master (output out_valid, output out_data, output out_par, input out_ready);
  modport slave  (input out_valid, input out_data, input out_par, output out_ready);
`else
  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
`endif
endinterface

// File: rtl/val_source_outreg.sv
// val_source_outreg: registered out_valid/out_data holding stage.
// Loads the seed on a start, advances by STEP on each handshake and holds
// otherwise, so data stays stable while the consumer stalls.
// Optional registered parity output when VAL_SOURCE_PARITY_EN is defined.
module val_source_outreg
  import val_source_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int STEP = DEF_STEP
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_load_vld,
  input  logic [W-1:0] i_seed,
  input  logic         i_hs,
  input  logic         i_last,
  output logic         o_valid,
  output logic [W-1:0] o_data
`ifdef VAL_SOURCE_PARITY_EN
  ,
  output logic         o_par
`endif
);

  localparam logic [W-1:0] C_STEP = STEP[W-1:0];

  logic         r_valid;
  logic [W-1:0] r_data;
  logic [W-1:0] w_data_nxt;

  assign w_data_nxt = r_data + C_STEP;

  // Beat register: load on start, advance on handshake, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_load_vld;
      r_data  <= i_seed;
    end else if (i_hs) begin
      r_valid <= !i_last;
      r_data  <= w_data_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

`ifdef VAL_SOURCE_PARITY_EN
  logic r_par;

  // Parity tracks the data register so both change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (i_load) begin
      r_par <= ^i_seed;
    end else if (i_hs) begin
      r_par <= ^w_data_nxt;
    end
  end

  assign o_par = r_par;
`endif

endmodule

// File: rtl/val_source.sv
// val_source: on start, emits len beats seed, seed+STEP, ... over a
// valid/ready channel, then pulses done for one cycle.
// Optional feature macro: VAL_SOURCE_PARITY_EN (adds out_par).
module val_source
  import val_source_pkg::*;
#(
  parameter int W     = params::P + 1,
  parameter int STEP  = DEF_STEP,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [W-1:0]     seed,
  output logic             busy,
  output logic             done,
  val_source_if.master     vs
);

  val_src_state_t   r_state;
  val_src_state_t   w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             w_hs;
  logic             w_load;
  logic             w_last;
  logic             w_valid;
  logic [W-1:0]     w_data;

  assign w_hs   = w_valid & vs.out_ready;
  assign w_load = (r_state == IDLE) & start;
  assign w_last = (r_rem == LEN_W'(1));

  // Next-state decode: start only matters in IDLE; FIN always lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = (len != '0) ? RUN : FIN;
      RUN:  if (w_hs && w_last) w_state_nxt = FIN;
      FIN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, beat counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == FIN);
      if (w_load) begin
        r_rem <= len;
      end else if (w_hs) begin
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

  val_source_outreg #(
    .W    (W),
    .STEP (STEP)
  ) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_vld (len != '0),
    .i_seed     (seed),
    .i_hs       (w_hs),
    .i_last     (w_last),
    .o_valid    (w_valid),
    .o_data     (w_data)
`ifdef VAL_SOURCE_PARITY_EN
    ,
    .o_par      (vs.out_par)
`endif
  );

  assign vs.out_valid = w_valid;
  assign vs.out_data  = w_data;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_val_source.sv
// tb_val_source: scoreboard bench for val_source. Stimulus pushes expected
// beats into a queue; a monitor pops and compares on every handshake.
module tb_val_source;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   len   = 8'd0;
  logic [W-1:0] seed  = '0;
  logic         busy;
  logic         done;

  val_source_if #(.W(W)) vs ();

  val_source #(.W(W), .STEP(1), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .seed  (seed),
    .busy  (busy),
    .done  (done),
    .vs    (vs)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_hs   = 0;
  int n_done = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, done counting.
  logic         pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [W-1:0] pd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prst && pv && !pr) begin
        check("stall_valid", int'(vs.out_valid), 1);
        check("stall_data", int'(vs.out_data), int'(pd));
      end
      if (vs.out_valid && vs.out_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat: got unexpected beat 0x%0h, expected none", vs.out_data);
        end else begin
          check("beat", int'(vs.out_data), int'(exp_q.pop_front()));
        end
      end
      if (done) n_done++;
`ifdef VAL_SOURCE_PARITY_EN
      if (vs.out_valid) check("par", int'(vs.out_par), int'(^vs.out_data));
`endif
    end
    prst = rst_n;
    pv   = vs.out_valid;
    pr   = vs.out_ready;
    pd   = vs.out_data;
  end

  // One burst: c counts cycles after the start edge; done expected at exp_cyc.
  task automatic burst(input string tag, input logic [7:0] s, input logic [7:0] l,
                       input logic [15:0] rpat, input int plen, input int exp_cyc,
                       input int inj);
    int hs0;
    int got;
    hs0 = n_hs;
    got = -1;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(s + 8'(i));
    seed  = s;
    len   = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed  = 8'h55;
    len   = 8'h33;
    for (int c = 0; c < 40; c++) begin
      vs.out_ready = (c < plen) ? rpat[c] : 1'b1;
      if (c == inj) begin
        start = 1'b1;
        seed  = 8'hAA;
        len   = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 0) check({tag, "_busy_first"}, int'(busy), 1);
      if (done && got < 0) got = c;
      if (got >= 0 && c == got + 1) begin
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_done_1cyc"}, int'(done), 0);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_cyc"}, got, exp_cyc);
    check({tag, "_hs_count"}, n_hs - hs0, int'(l));
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int nd0;
  initial begin
    vs.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(vs.out_valid), 0);
    check("rst_data", int'(vs.out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    burst("basic", 8'h10, 8'd4, 16'h0000, 0, 4, -1);
    burst("wrap",  8'hFE, 8'd4, 16'h0000, 0, 4, -1);
    burst("stall", 8'h00, 8'd3, 16'h0029, 6, 6, -1);
    burst("len0",  8'h05, 8'd0, 16'h0000, 0, 0, -1);
    burst("inject", 8'h30, 8'd4, 16'h0000, 0, 4, 1);

    // Reset mid-burst after two accepted beats.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h20 + 8'(i));
    vs.out_ready = 1'b1;
    seed  = 8'h20;
    len   = 8'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_data_before_rst", int'(vs.out_data), 8'h22);
    nd0   = n_done;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_valid", int'(vs.out_valid), 0);
    check("arst_data", int'(vs.out_data), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", n_done - nd0, 0);
    check("arst_idle", int'(busy), 0);
    burst("fresh", 8'h40, 8'd2, 16'h0000, 0, 2, -1);

`ifdef VAL_SOURCE_PARITY_EN
    @(posedge clk); #1;
    exp_q.push_back(8'h07);
    vs.out_ready = 1'b0;
    seed  = 8'h07;
    len   = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("par_07_data", int'(vs.out_data), 8'h07);
    check("par_07", int'(vs.out_par), 1);
    @(posedge clk); #1;
    vs.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("par_q_empty", exp_q.size(), 0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
